// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative radix-2 restoring integer divider (signed/unsigned),
//                one quotient bit per cycle, valid/ready request and response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_dividend_abs;
    logic [WIDTH-1:0]   w_divisor_abs;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_dq_next;

    assign in_ready    = (r_state == c_st_idle);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

    assign w_accept   = in_valid && in_ready;
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_cnt_one);

    assign w_dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The partial remainder is always below the divisor, so after the
    // conditional subtract it fits back into WIDTH bits; only the compare
    // needs the extra shifted-out bit.
    assign w_shift    = {r_rem, r_dq[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    assign w_dq_next  = {r_dq[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_next = w_div_zero ? c_st_done : c_st_busy;
            c_st_busy: if (w_last) w_state_next = c_st_done;
            c_st_done: if (r_out_valid && out_ready) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Result is presented one cycle after the result registers load.
            r_out_valid <= (r_state == c_st_done) && !(r_out_valid && out_ready);

            if (w_accept) begin
                if (w_div_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end else begin
                    r_dq    <= w_dividend_abs;
                    r_rem   <= '0;
                    r_dvs   <= w_divisor_abs;
                    r_neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_r <= is_signed && dividend[WIDTH-1];
                    r_cnt   <= c_cnt_init;
                end
            end

            if (r_state == c_st_busy) begin
                r_dq  <= w_dq_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - c_cnt_one;
                if (w_last) begin
                    r_quotient  <= r_neg_q ? -w_dq_next  : w_dq_next;
                    r_remainder <= r_neg_r ? -w_rem_next : w_rem_next;
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request, wait for the result, optionally hold backpressure,
    // then accept it and confirm the return to IDLE.
    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input int exp_lat, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0005;
        is_signed = ~sgn;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_q"}, 64'(quotient), 64'(exp_q));
        check_eq({tag, "_r"}, 64'(remainder), 64'(exp_r));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_bp_q"}, 64'(quotient), 64'(exp_q));
            check_eq({tag, "_bp_r"}, 64'(remainder), 64'(exp_r));
            check_eq({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_idle"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_q_kept"}, 64'(quotient), 64'(exp_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_q", 64'(quotient), 64'd0);
        check_eq("rst_r", 64'(remainder), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div("u100_7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33, 0);
        do_div("sm100_7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, 0);
        do_div("s100_m7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33, 0);
        do_div("sm100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33, 0);
        do_div("divzero",  1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1,  0);
        do_div("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33, 0);
        do_div("u_max_1",  1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 33, 0);
        do_div("u_msb",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33, 0);
        do_div("bp",       1'b0, 32'd1000,     32'd3,        32'd333,      32'd1,        1'b0, 33, 10);
        do_div("b2b",      1'b0, 32'd50,       32'd5,        32'd10,       32'd0,        1'b0, 33, 0);

        // Reset in the middle of an operation must discard it.
        is_signed = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_q", 64'(quotient), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("midrst_no_stale", 64'(out_valid), 64'd0);
        do_div("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
